// File: rtl/results_buffer_arbiter_pkg.sv
// rtl/results_buffer_arbiter_pkg.sv - shared encodings for the results buffer arbiter
//
// Purpose: read-slot state encoding, grant-owner encoding and request-vector
// bit positions shared by results_buffer_arbiter and rr_arb2.
// Ports: none (package).
package results_buffer_arbiter_pkg;

  // Read-response slot: idle, SRAM read in flight, response held for the host.
  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_PEND  = 2'd1,
    SLOT_FULL  = 2'd2
  } slot_e;

  // Owner of the most recent SRAM grant; the value also equals the
  // request-vector bit index of that requester.
  typedef enum logic {
    OWNER_WRITE = 1'b0,
    OWNER_READ  = 1'b1
  } owner_e;

  localparam int unsigned REQ_WR = 0;
  localparam int unsigned REQ_RD = 1;

endpackage

// File: rtl/results_buffer_arbiter_rr_arb2.sv
// rtl/results_buffer_arbiter_rr_arb2.sv - two-requester round-robin arbiter with a one-bit pointer
//
// Purpose: grants a lone requester immediately; on a conflict grants the
// requester that did not win last time.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   req[1:0]    request vector (bit 0 write, bit 1 read)
//   grant[1:0]  one-hot (or zero) combinational grant vector
module rr_arb2
  import results_buffer_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  owner_e last_q;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_q == OWNER_READ) ? 2'b01 : 2'b10;
    end
  end

  // Reset to READ so that the write side wins the first conflict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= OWNER_READ;
    end else if (grant[REQ_RD]) begin
      last_q <= OWNER_READ;
    end else if (grant[REQ_WR]) begin
      last_q <= OWNER_WRITE;
    end
  end

endmodule

// File: rtl/results_buffer_arbiter.sv
// rtl/results_buffer_arbiter.sv - arbitrates accumulator writes and host reads onto a single-port results SRAM
//
// Purpose: shares one external single-port SRAM between the accumulator drain
// (writes) and the host unload path (reads), with a one-entry read-response
// slot. Read latency is two cycles from grant to resp_valid.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   wr_valid/wr_ready          write request handshake, wr_addr/wr_data payload
//   rd_valid/rd_ready          read request handshake, rd_addr payload
//   resp_valid/resp_ready      read response handshake, resp_data payload
//   sram_we/sram_addr/sram_din SRAM control, sram_dout registered SRAM read data
module results_buffer_arbiter
  import results_buffer_arbiter_pkg::*;
#(
  parameter int ADDRESSSIZE = 10,
  parameter int WORDSIZE    = 160
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDRESSSIZE-1:0] wr_addr,
  input  logic [WORDSIZE-1:0]    wr_data,
  input  logic                   rd_valid,
  output logic                   rd_ready,
  input  logic [ADDRESSSIZE-1:0] rd_addr,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WORDSIZE-1:0]    resp_data,
  output logic                   sram_we,
  output logic [ADDRESSSIZE-1:0] sram_addr,
  output logic [WORDSIZE-1:0]    sram_din,
  input  logic [WORDSIZE-1:0]    sram_dout
);

  slot_e                  slot_q, slot_d;
  logic [ADDRESSSIZE-1:0] addr_q;
  logic [WORDSIZE-1:0]    resp_data_q;
  logic [1:0]             req, grant;
  logic                   rd_eligible;

  // Gating by rst_n keeps every output quiet during reset even though the
  // registers only clear at the next edge.
  assign resp_valid = rst_n && (slot_q == SLOT_FULL);

  // A held response may be replaced in the same cycle it is consumed; a read
  // in flight blocks new reads.
  assign rd_eligible = rd_valid &&
                       ((slot_q == SLOT_EMPTY) ||
                        ((slot_q == SLOT_FULL) && resp_valid && resp_ready));

  assign req[REQ_WR] = rst_n && wr_valid;
  assign req[REQ_RD] = rst_n && rd_eligible;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .grant (grant)
  );

  assign wr_ready  = grant[REQ_WR];
  assign rd_ready  = grant[REQ_RD];
  assign sram_we   = grant[REQ_WR];
  assign sram_din  = wr_data;
  assign resp_data = resp_data_q;

  always_comb begin
    sram_addr = addr_q;
    if (!rst_n) begin
      sram_addr = '0;
    end else if (grant[REQ_WR]) begin
      sram_addr = wr_addr;
    end else if (grant[REQ_RD]) begin
      sram_addr = rd_addr;
    end
  end

  always_comb begin
    slot_d = slot_q;
    case (slot_q)
      SLOT_EMPTY: if (grant[REQ_RD]) slot_d = SLOT_PEND;
      // The SRAM holds its output through a write, so a write granted here
      // does not disturb the capture.
      SLOT_PEND:  slot_d = SLOT_FULL;
      SLOT_FULL: begin
        if (grant[REQ_RD]) begin
          slot_d = SLOT_PEND;
        end else if (resp_ready) begin
          slot_d = SLOT_EMPTY;
        end
      end
      default:    slot_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= SLOT_EMPTY;
      addr_q <= '0;
    end else begin
      slot_q <= slot_d;
      if (grant != 2'b00) begin
        addr_q <= sram_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && (slot_q == SLOT_PEND)) begin
      resp_data_q <= sram_dout;
    end
  end

endmodule

// File: tb/tb_results_buffer_arbiter.sv
// tb/tb_results_buffer_arbiter.sv - directed self-checking bench for results_buffer_arbiter
module tb_results_buffer_arbiter;

  localparam int AW = 10;
  localparam int DW = 160;

  logic          clk;
  logic          rst_n;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] rd_addr;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_data;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;

  int tests_run;
  int tests_failed;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  results_buffer_arbiter #(.ADDRESSSIZE(AW), .WORDSIZE(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_addr    (rd_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM with registered read data that holds during writes.
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_din;
    else         sram_dout      <= mem[sram_addr];
  end

  function automatic logic [DW-1:0] word_of(input int a);
    logic [31:0] w;
    w = 32'hC0DE_0000 | a;
    return {5{w}};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1; resp_ready = 1'b1;
    wr_addr = 10'd3; rd_addr = 10'd4; wr_data = '1;
    @(negedge clk); @(negedge clk); #1;
    tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
    tests_run++; if (rd_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_ready got %b want 0", rd_ready); end
    tests_run++; if (sram_we !== 1'b0) begin tests_failed++; $display("FAIL reset_sram_we got %b want 0", sram_we); end
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    tests_run++; if (sram_addr !== 10'd0) begin tests_failed++; $display("FAIL reset_sram_addr got %0d want 0", sram_addr); end
    @(negedge clk);
    rst_n = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0;
  endtask

  task automatic test_write_read();
    logic [DW-1:0] aa;
    aa = {20{8'hAA}};
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 10'd5; wr_data = aa; rd_valid = 1'b0; resp_ready = 1'b1;
    #1;
    tests_run++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin tests_failed++; $display("FAIL wr_grant got w=%b r=%b want w=1 r=0", wr_ready, rd_ready); end
    tests_run++; if (sram_we !== 1'b1 || sram_addr !== 10'd5 || sram_din !== aa) begin tests_failed++; $display("FAIL wr_sram got we=%b addr=%0d din=%h want we=1 addr=5", sram_we, sram_addr, sram_din); end
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10'd5;
    #1;
    tests_run++; if (rd_ready !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 10'd5) begin tests_failed++; $display("FAIL rd_grant got rdy=%b we=%b addr=%0d want 1 0 5", rd_ready, sram_we, sram_addr); end
    @(negedge clk);
    rd_valid = 1'b0; rd_addr = 10'd99;
    #1;
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_latency_t1 resp_valid got %b want 0", resp_valid); end
    tests_run++; if (sram_addr !== 10'd5 || sram_we !== 1'b0) begin tests_failed++; $display("FAIL idle_addr_hold got addr=%0d we=%b want 5 0", sram_addr, sram_we); end
    @(negedge clk); #1;
    tests_run++; if (resp_valid !== 1'b1 || resp_data !== aa) begin tests_failed++; $display("FAIL rd_resp got v=%b data=%h want v=1 data=%h", resp_valid, resp_data, aa); end
    @(negedge clk); #1;
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL resp_drain got %b want 0", resp_valid); end
  endtask

  task automatic test_alternate();
    logic [3:0] exp_w;
    exp_w = 4'b0101;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      wr_valid = 1'b1; wr_addr = 10'd20; wr_data = word_of(500 + i);
      rd_valid = 1'b1; rd_addr = 10'd21; resp_ready = 1'b1;
      #1;
      tests_run++;
      if (wr_ready !== exp_w[i] || rd_ready !== ~exp_w[i]) begin
        tests_failed++; $display("FAIL alternate_cycle%0d got w=%b r=%b want w=%b r=%b", i, wr_ready, rd_ready, exp_w[i], ~exp_w[i]);
      end
    end
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    rd_valid = 1'b1; rd_addr = 10'd7; resp_ready = 1'b0; wr_valid = 1'b0;
    #1;
    tests_run++; if (rd_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_first_grant got %b want 1", rd_ready); end
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 10'd30; wr_data = word_of(900);
    #1;
    tests_run++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_write_in_pend got w=%b r=%b want w=1 r=0", wr_ready, rd_ready); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wr_addr = 10'(31 + i); wr_data = word_of(901 + i);
      #1;
      tests_run++;
      if (rd_ready !== 1'b0 || wr_ready !== 1'b1 || resp_valid !== 1'b1 || resp_data !== word_of(7)) begin
        tests_failed++; $display("FAIL bp_hold_cycle%0d got r=%b w=%b v=%b data=%h want 0 1 1 %h", i, rd_ready, wr_ready, resp_valid, resp_data, word_of(7));
      end
    end
    @(negedge clk);
    rd_valid = 1'b0; wr_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int idx, rsp, last_g;
    idx = 0; rsp = 0; last_g = -1;
    resp_ready = 1'b1; wr_valid = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      rd_valid = (idx < 3);
      rd_addr  = 10'(idx + 1);
      #1;
      if (rd_ready) begin
        if (last_g >= 0) begin
          tests_run++;
          if (cyc - last_g != 2) begin tests_failed++; $display("FAIL b2b_spacing got %0d want 2", cyc - last_g); end
        end
        last_g = cyc;
        idx++;
      end
      if (resp_valid) begin
        tests_run++;
        if (resp_data !== word_of(rsp + 1)) begin tests_failed++; $display("FAIL b2b_order%0d got %h want %h", rsp, resp_data, word_of(rsp + 1)); end
        rsp++;
      end
    end
    rd_valid = 1'b0;
    tests_run++; if (idx != 3 || rsp != 3) begin tests_failed++; $display("FAIL b2b_count got grants=%0d resps=%0d want 3 3", idx, rsp); end
  endtask

  task automatic test_raw();
    logic [DW-1:0] nw;
    nw = {5{32'h1357_9BDF}};
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 10'd9; wr_data = nw; rd_valid = 1'b0; resp_ready = 1'b1;
    #1;
    tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL raw_write got %b want 1", wr_ready); end
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10'd9;
    #1;
    tests_run++; if (rd_ready !== 1'b1) begin tests_failed++; $display("FAIL raw_read_grant got %b want 1", rd_ready); end
    @(negedge clk);
    rd_valid = 1'b0;
    @(negedge clk); #1;
    tests_run++; if (resp_valid !== 1'b1 || resp_data !== nw) begin tests_failed++; $display("FAIL raw_data got v=%b data=%h want v=1 data=%h", resp_valid, resp_data, nw); end
    @(negedge clk);
  endtask

  task automatic test_reset_pend();
    @(negedge clk);
    rd_valid = 1'b1; rd_addr = 10'd2; resp_ready = 1'b1; wr_valid = 1'b0;
    #1;
    tests_run++; if (rd_ready !== 1'b1) begin tests_failed++; $display("FAIL rstp_grant got %b want 1", rd_ready); end
    @(negedge clk);
    rd_valid = 1'b0; rst_n = 1'b0; wr_valid = 1'b1; wr_addr = 10'd44;
    #1;
    tests_run++;
    if (wr_ready !== 1'b0 || rd_ready !== 1'b0 || sram_we !== 1'b0 || resp_valid !== 1'b0 || sram_addr !== 10'd0) begin
      tests_failed++; $display("FAIL rstp_outputs got w=%b r=%b we=%b v=%b addr=%0d want 0 0 0 0 0", wr_ready, rd_ready, sram_we, resp_valid, sram_addr);
    end
    @(negedge clk);
    rst_n = 1'b1; wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL rstp_no_resp%0d got %b want 0", i, resp_valid); end
      @(negedge clk);
    end
    wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 10'd45; rd_addr = 10'd1;
    #1;
    tests_run++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin tests_failed++; $display("FAIL rstp_first_conflict got w=%b r=%b want w=1 r=0", wr_ready, rd_ready); end
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tests_run = 0; tests_failed = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = word_of(i);
    rst_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; resp_ready = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    test_reset();
    test_write_read();
    test_alternate();
    test_backpressure();
    test_back_to_back();
    test_raw();
    test_reset_pend();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/results_buffer_arbiter.md
RESULTS_BUFFER_ARBITER -- requirements
Module: results_buffer_arbiter

Interface
REQ-001 Parameter ADDRESSSIZE, default 10, SHALL set the SRAM address width.
REQ-002 Parameter WORDSIZE, default 160, SHALL set the SRAM data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 wr_valid / wr_ready  input / output  1 / 1  SHALL form the write-request handshake from the accumulator drain.
REQ-006 wr_addr / wr_data  input  ADDRESSSIZE / WORDSIZE  SHALL be the write address and data, valid while wr_valid=1.
REQ-007 rd_valid / rd_ready  input / output  1 / 1  SHALL form the read-request handshake from the host unload path.
REQ-008 rd_addr  input  ADDRESSSIZE  SHALL be the read address, valid while rd_valid=1.
REQ-009 resp_valid / resp_ready  output / input  1 / 1  SHALL form the read-response handshake.
REQ-010 resp_data  output  WORDSIZE  SHALL be the read data, valid while resp_valid=1.
REQ-011 sram_we / sram_addr / sram_din  output  1 / ADDRESSSIZE / WORDSIZE  SHALL drive the single-port results SRAM.
REQ-012 sram_dout  input  WORDSIZE  SHALL be the SRAM registered read data, valid one cycle after a read cycle (we=0).

Function
REQ-013 A transfer SHALL occur only on a cycle where valid and ready are both 1.
REQ-014 The read slot SHALL have three states: EMPTY, PEND (SRAM read in flight), FULL (resp_data held).
REQ-015 rd_eligible SHALL equal rd_valid and (slot EMPTY, or slot FULL with resp_valid and resp_ready both 1 this cycle).
REQ-016 If only one requester is eligible it SHALL be granted; if both are, the one not granted last SHALL win (round-robin, 1-bit last_grant).
REQ-017 wr_ready and rd_ready SHALL be combinational grant outputs; at most one SHALL be 1 per cycle.
REQ-018 On a write grant: sram_we=1, sram_addr=wr_addr, sram_din=wr_data, combinationally in the same cycle.
REQ-019 On a read grant: sram_we=0, sram_addr=rd_addr; slot SHALL move to PEND at the next edge.
REQ-020 With no grant: sram_we=0, sram_addr SHALL hold its last granted value, sram_din don't-care.
REQ-021 In PEND, sram_dout SHALL be captured into resp_data at the next edge and the slot SHALL move to FULL; resp_valid=1 from that cycle (read latency: grant at T, resp_valid at T+2).
REQ-022 A PEND cycle SHALL NOT be a read grant; a write grant in PEND SHALL be allowed (SRAM output held during write).
REQ-023 FULL with resp_ready=1 and no new read grant SHALL return the slot to EMPTY; with a concurrent read grant it SHALL go to PEND.
REQ-024 resp_data SHALL remain stable while resp_valid=1 and resp_ready=0.
REQ-025 Write to address A at cycle T followed by read of A granted at T+1 or later SHALL return the new data.

Reset
REQ-026 While rst_n=0: wr_ready=0, rd_ready=0, sram_we=0, resp_valid=0, slot EMPTY, last_grant=READ (write wins first conflict), sram_addr=0.
REQ-027 Reset asserted with slot PEND or FULL SHALL discard the in-flight response; no resp_valid after rst_n rises until a new read is granted.

Structure
REQ-028 Slot-state encoding and the grant-owner encoding SHALL live in the shared buffer package.
REQ-029 The round-robin arbiter SHALL be one sub-module, rr_arb2 (two requests, two grants, one-bit pointer).
REQ-030 The SRAM SHALL remain external; this block SHALL contain no memory array.

Verification
REQ-031 Write 0xAA..AA to 5, then read 5 with resp_ready=1 -> resp_valid two cycles after rd grant, resp_data=0xAA..AA.
REQ-032 wr_valid and rd_valid both held high with slot free, after reset -> grants alternate W,R,W,R starting with W.
REQ-033 Read 7 with resp_ready=0 for 10 cycles, rd_valid held -> rd_ready=0 throughout, resp_data stable, writes still granted.
REQ-034 Back-to-back reads 1,2,3 with resp_ready=1 -> one read grant per two cycles; responses in order 1,2,3.
REQ-035 Write 9 at T, read 9 at T+1 -> new data returned.
REQ-036 rst_n low during PEND -> resp_valid stays 0 after reset; outputs match REQ-026.
